// File: rtl/au_gray_cnt_if.sv
// au_gray_cnt_if: control and count bus between a controller and the Gray counter
interface au_gray_cnt_if #(parameter int WIDTH = 8);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             en;
  logic             dn;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] b;
  logic             wrap;
  modport master (output clr, load, d, en, dn, input g, b, wrap);
  modport slave  (input clr, load, d, en, dn, output g, b, wrap);
endinterface

// File: rtl/au_gray_cnt.sv
// au_gray_cnt: binary/Gray up/down counter with registered Gray output and wrap pulse
module au_gray_cnt #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  au_gray_cnt_if.slave bus
);
  logic [WIDTH-1:0] b_q, g_q, b_step, b_nxt, g_nxt;
  logic             wrap_q, wrap_nxt;
  // next binary/Gray/wrap values; Gray comes from the next binary so both land on the same edge
  always_comb begin
    b_step   = bus.dn ? b_q - 1'b1 : b_q + 1'b1;
    b_nxt    = bus.clr ? '0 : bus.load ? bus.d : bus.en ? b_step : b_q;
    wrap_nxt = !bus.clr && !bus.load && bus.en && (bus.dn ? (b_q == '0) : (b_q == '1));
    g_nxt    = b_nxt ^ (b_nxt >> 1);
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q    <= '0;
      g_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      b_q    <= b_nxt;
      g_q    <= g_nxt;
      wrap_q <= wrap_nxt;
    end
  end
  assign bus.b    = b_q;
  assign bus.g    = g_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_au_gray_cnt.sv
// tb_au_gray_cnt: directed checks of the Gray counter with a bench-side Gray-to-binary converter
module tb_au_gray_cnt;
  localparam int W = 8;
  localparam int N = (1 << W) + 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  au_gray_cnt_if #(.WIDTH(W)) bus();
  au_gray_cnt #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [W-1:0] eb, input logic [W-1:0] eg, input logic ew);
    chk({tag, ".b"}, 32'(bus.b), 32'(eb));
    chk({tag, ".g"}, 32'(bus.g), 32'(eg));
    chk({tag, ".wrap"}, 32'(bus.wrap), 32'(ew));
  endtask

  task automatic step(input logic c, input logic l, input logic [W-1:0] dv, input logic e, input logic n);
    bus.clr = c; bus.load = l; bus.d = dv; bus.en = e; bus.dn = n;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] g2b(input logic [W-1:0] gv);
    logic [W-1:0] r;
    r[W-1] = gv[W-1];
    for (int i = W - 2; i >= 0; i--) r[i] = r[i+1] ^ gv[i];
    return r;
  endfunction

  initial begin
    logic [7:0] gseq [6];
    logic [W-1:0] mb, pg;
    int wraps;
    gseq = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07};
    bus.clr = 0; bus.load = 0; bus.d = '0; bus.en = 0; bus.dn = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk3("rst_init", 8'h00, 8'h00, 1'b0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk3("pre_rst", 8'h03, 8'h02, 1'b0);
    #2 rst = 1;
    #1 chk3("rst_async", 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #1 chk3("rst_hold", 8'h00, 8'h00, 1'b0);
    rst = 0;
    chk3("up0", 8'h00, gseq[0], 1'b0);
    for (int i = 1; i < 6; i++) begin
      step(0, 0, 0, 1, 0);
      chk3($sformatf("up%0d", i), W'(i), gseq[i], 1'b0);
    end
    step(0, 1, 8'hFE, 0, 0);
    chk3("ld_fe", 8'hFE, 8'h81, 1'b0);
    step(0, 0, 0, 1, 0);
    chk3("wup_ff", 8'hFF, 8'h80, 1'b0);
    step(0, 0, 0, 1, 0);
    chk3("wup_00", 8'h00, 8'h00, 1'b1);
    step(0, 0, 0, 1, 1);
    chk3("wdn_ff", 8'hFF, 8'h80, 1'b1);
    step(0, 0, 0, 1, 1);
    chk3("wdn_fe", 8'hFE, 8'h81, 1'b0);
    step(0, 1, 8'h5A, 1, 0);
    chk3("ld_en", 8'h5A, 8'h77, 1'b0);
    step(1, 1, 8'h33, 1, 0);
    chk3("clr_ld", 8'h00, 8'h00, 1'b0);
    step(0, 1, 8'h5A, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 8'hC3, 0, i[0]);
      chk3($sformatf("hold%0d", i), 8'h5A, 8'h77, 1'b0);
    end
    step(0, 1, 8'hFF, 0, 0);
    step(1, 0, 0, 1, 0);
    chk3("clr_wrap", 8'h00, 8'h00, 1'b0);
    step(0, 1, 8'hFF, 0, 0);
    step(0, 1, 8'h00, 1, 0);
    chk3("ld_nowrap", 8'h00, 8'h00, 1'b0);
    for (int dir = 0; dir < 2; dir++) begin
      wraps = 0;
      mb = bus.b;
      pg = bus.g;
      for (int i = 0; i < N; i++) begin
        step(0, 0, 0, 1, dir[0]);
        mb = dir[0] ? mb - 1'b1 : mb + 1'b1;
        chk($sformatf("walk%0d_b%0d", dir, i), 32'(bus.b), 32'(mb));
        chk($sformatf("walk%0d_1bit%0d", dir, i), 32'($countones(bus.g ^ pg)), 32'd1);
        chk($sformatf("walk%0d_conv%0d", dir, i), 32'(g2b(bus.g)), 32'(bus.b));
        if (bus.wrap) wraps++;
        pg = bus.g;
      end
      chk($sformatf("walk%0d_wraps", dir), 32'(wraps), 32'd1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
